// File: rtl/fpsqrt_req_issue.sv
// Request FIFO + start/finish handshake front end for the scalar sqrt unit.
// Optional FIFO bypass when idle and empty: define FPSQRT_ISSUE_BYPASS_EN.
module fpsqrt_req_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [63:0]              req_op_i,
  input  logic [1:0]               req_fmt_i,
  input  logic [2:0]               req_rm_i,
  input  logic [TAG_W-1:0]         req_tag_i,
  input  logic                     flush_i,
  output logic                     sqrt_start_valid_o,
  input  logic                     sqrt_start_ready_i,
  output logic [63:0]              sqrt_op_o,
  output logic [1:0]               sqrt_fmt_o,
  output logic [2:0]               sqrt_rm_o,
  output logic                     sqrt_flush_o,
  input  logic                     sqrt_finish_valid_i,
  output logic                     sqrt_finish_ready_o,
  input  logic [63:0]              sqrt_res_i,
  input  logic [4:0]               sqrt_fflags_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [63:0]              rsp_res_o,
  output logic [4:0]               rsp_fflags_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [63:0]      op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  ent_t             mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [TAG_W-1:0] inflight_q, inflight_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_res_q, rsp_res_d;
  logic [4:0]       rsp_fflags_q, rsp_fflags_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  ent_t in_ent, head, issue_ent;
  logic empty, full, byp;
  logic start_valid, fin_ready, req_ready;
  logic start_hs, fin_hs, req_hs, rsp_hs;
  logic push, pop;

  assign in_ent = '{op: req_op_i, fmt: req_fmt_i,
                    rm: req_rm_i, tag: req_tag_i};
  assign head   = mem_q[rptr_q[AW-1:0]];
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                & (wptr_q[AW] != rptr_q[AW]);

`ifdef FPSQRT_ISSUE_BYPASS_EN
  assign byp = (state_q == IDLE) & empty;
`else
  assign byp = 1'b0;
`endif

  assign issue_ent = byp ? in_ent : head;

  always_comb begin
    state_d     = state_q;
    start_valid = 1'b0;
    fin_ready   = 1'b0;
    req_ready   = !full & !flush_i;
    if (byp) req_ready = (sqrt_start_ready_i | !full) & !flush_i;
    unique case (state_q)
      IDLE: begin
        if (byp) start_valid = req_valid_i & !flush_i;
        else     start_valid = !empty & !flush_i;
        if (start_valid & sqrt_start_ready_i) state_d = BUSY;
      end
      BUSY: begin
        fin_ready = (!rsp_valid_q | rsp_ready_i) & !flush_i;
        if (fin_ready & sqrt_finish_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign start_hs = start_valid & sqrt_start_ready_i;
  assign fin_hs   = fin_ready & sqrt_finish_valid_i;
  assign req_hs   = req_valid_i & req_ready;
  assign rsp_hs   = rsp_valid_q & rsp_ready_i;
  // A bypassed request that starts immediately never occupies a slot.
  assign push     = req_hs & !(byp & start_hs);
  assign pop      = start_hs & !byp;

  always_comb begin
    wptr_d       = wptr_q + PW'(push);
    rptr_d       = rptr_q + PW'(pop);
    inflight_d   = start_hs ? issue_ent.tag : inflight_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_res_d    = rsp_res_q;
    rsp_fflags_d = rsp_fflags_q;
    rsp_tag_d    = rsp_tag_q;
    if (rsp_hs) rsp_valid_d = 1'b0;
    if (fin_hs) begin
      rsp_valid_d  = 1'b1;
      rsp_res_d    = sqrt_res_i;
      rsp_fflags_d = sqrt_fflags_i;
      rsp_tag_d    = inflight_q;
    end
    if (flush_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      inflight_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_res_q    <= '0;
      rsp_fflags_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      inflight_q   <= inflight_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_res_q    <= rsp_res_d;
      rsp_fflags_q <= rsp_fflags_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign req_ready_o         = req_ready;
  assign sqrt_start_valid_o  = start_valid;
  assign sqrt_op_o           = issue_ent.op;
  assign sqrt_fmt_o          = issue_ent.fmt;
  assign sqrt_rm_o           = issue_ent.rm;
  assign sqrt_flush_o        = flush_i;
  assign sqrt_finish_ready_o = fin_ready;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_res_o           = rsp_res_q;
  assign rsp_fflags_o        = rsp_fflags_q;
  assign rsp_tag_o           = rsp_tag_q;
  assign fifo_cnt_o          = wptr_q - rptr_q;
  assign busy_o              = (state_q == BUSY) | !empty | rsp_valid_q;

endmodule

// File: tb/tb_fpsqrt_req_issue.sv
// Bench for fpsqrt_req_issue: table-driven fill/flush, hand sequences,
// and randomized traffic against a queue-based in-order reference.
module tb_fpsqrt_req_issue;

`ifdef FPSQRT_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] K = 64'h5A5A_0F0F_A5A5_F0F0;

  logic        clk, rst_n;
  logic        req_valid_i, req_ready_o;
  logic [63:0] req_op_i;
  logic [1:0]  req_fmt_i;
  logic [2:0]  req_rm_i;
  logic [4:0]  req_tag_i;
  logic        flush_i;
  logic        sqrt_start_valid_o, sqrt_start_ready_i;
  logic [63:0] sqrt_op_o;
  logic [1:0]  sqrt_fmt_o;
  logic [2:0]  sqrt_rm_o;
  logic        sqrt_flush_o;
  logic        sqrt_finish_valid_i, sqrt_finish_ready_o;
  logic [63:0] sqrt_res_i;
  logic [4:0]  sqrt_fflags_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [63:0] rsp_res_o;
  logic [4:0]  rsp_fflags_o;
  logic [4:0]  rsp_tag_o;
  logic [2:0]  fifo_cnt_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  fpsqrt_req_issue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_fmt_i(req_fmt_i),
    .req_rm_i(req_rm_i), .req_tag_i(req_tag_i),
    .flush_i(flush_i),
    .sqrt_start_valid_o(sqrt_start_valid_o),
    .sqrt_start_ready_i(sqrt_start_ready_i),
    .sqrt_op_o(sqrt_op_o), .sqrt_fmt_o(sqrt_fmt_o),
    .sqrt_rm_o(sqrt_rm_o), .sqrt_flush_o(sqrt_flush_o),
    .sqrt_finish_valid_i(sqrt_finish_valid_i),
    .sqrt_finish_ready_o(sqrt_finish_ready_o),
    .sqrt_res_i(sqrt_res_i), .sqrt_fflags_i(sqrt_fflags_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_fflags_o(rsp_fflags_o),
    .rsp_tag_o(rsp_tag_o), .fifo_cnt_o(fifo_cnt_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] op;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [4:0]  tag;
  } req_t;

  typedef struct {
    bit       rv;
    bit [4:0] tag;
    bit       sr, fv, fl;
    bit       e_sv, e_rr;
    bit [2:0] e_cnt;
    bit       e_fr, e_busy, chk_op;
    bit [4:0] op_tag;
  } row_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] op_of(input logic [4:0] t);
    return 64'h4010_0000_0000_0000 | 64'(t);
  endfunction

  task automatic idle_inputs();
    req_valid_i = 0; req_op_i = '0; req_fmt_i = '0;
    req_rm_i = '0; req_tag_i = '0; flush_i = 0;
    sqrt_start_ready_i = 0; sqrt_finish_valid_i = 0;
    sqrt_res_i = '0; sqrt_fflags_i = '0; rsp_ready_i = 0;
  endtask

  task automatic run_table();
    row_t tbl [10];
    //         rv tag sr fv fl  sv   rr cnt fr bsy chk optag
    tbl[0] = '{1, 10, 0, 0, 0, BYP, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 11, 0, 0, 0, 1,   1, 1, 0, 1, 1, 10};
    tbl[2] = '{1, 12, 0, 0, 0, 1,   1, 2, 0, 1, 1, 10};
    tbl[3] = '{1, 13, 0, 0, 0, 1,   1, 3, 0, 1, 1, 10};
    tbl[4] = '{1, 14, 0, 0, 0, 1,   0, 4, 0, 1, 1, 10};
    tbl[5] = '{1, 14, 1, 0, 0, 1,   0, 4, 0, 1, 1, 10};
    tbl[6] = '{1, 14, 0, 0, 0, 0,   1, 3, 1, 1, 0, 0};
    tbl[7] = '{0, 0,  0, 0, 0, 0,   0, 4, 1, 1, 0, 0};
    tbl[8] = '{0, 0,  0, 1, 1, 0,   0, 4, 0, 1, 0, 0};
    tbl[9] = '{0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_valid_i = tbl[i].rv;
      req_tag_i = tbl[i].tag;
      req_op_i = op_of(tbl[i].tag);
      req_fmt_i = 2'd1; req_rm_i = 3'd2;
      sqrt_start_ready_i = tbl[i].sr;
      sqrt_finish_valid_i = tbl[i].fv;
      flush_i = tbl[i].fl;
      rsp_ready_i = 1;
      #1;
      chk($sformatf("tbl%0d.start_valid", i),
          64'(sqrt_start_valid_o), 64'(tbl[i].e_sv));
      chk($sformatf("tbl%0d.req_ready", i),
          64'(req_ready_o), 64'(tbl[i].e_rr));
      chk($sformatf("tbl%0d.fifo_cnt", i),
          64'(fifo_cnt_o), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.fin_ready", i),
          64'(sqrt_finish_ready_o), 64'(tbl[i].e_fr));
      chk($sformatf("tbl%0d.busy", i),
          64'(busy_o), 64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.rsp_valid", i), 64'(rsp_valid_o), 64'd0);
      chk($sformatf("tbl%0d.sqrt_flush", i),
          64'(sqrt_flush_o), 64'(tbl[i].fl));
      if (tbl[i].chk_op)
        chk($sformatf("tbl%0d.sqrt_op", i),
            sqrt_op_o, op_of(tbl[i].op_tag));
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic single_op();
    logic [63:0] op;
    op = 64'h4010_0000_0000_0000;
    @(posedge clk); #1;
    req_valid_i = 1; req_op_i = op; req_tag_i = 5;
    req_fmt_i = 2'd1; req_rm_i = 3'd0;
    sqrt_start_ready_i = 1;
    #1;
    chk("t1.start_valid_t0", 64'(sqrt_start_valid_o), 64'(BYP));
    chk("t1.req_ready_t0", 64'(req_ready_o), 64'd1);
    if (sqrt_start_valid_o) chk("t1.op_t0", sqrt_op_o, op);
    @(posedge clk); #1;
    req_valid_i = 0;
    #1;
    chk("t1.fifo_cnt_t1", 64'(fifo_cnt_o), 64'(!BYP));
    chk("t1.start_valid_t1", 64'(sqrt_start_valid_o), 64'(!BYP));
    if (sqrt_start_valid_o) begin
      chk("t1.op_t1", sqrt_op_o, op);
      chk("t1.fmt_t1", 64'(sqrt_fmt_o), 64'd1);
    end
    @(posedge clk); #1;
    sqrt_start_ready_i = 0;
    sqrt_finish_valid_i = 1;
    sqrt_res_i = 64'h4000_0000_0000_0000;
    sqrt_fflags_i = 5'h01;
    rsp_ready_i = 0;
    #1;
    chk("t1.start_valid_busy", 64'(sqrt_start_valid_o), 64'd0);
    chk("t1.fin_ready", 64'(sqrt_finish_ready_o), 64'd1);
    chk("t1.fifo_cnt_busy", 64'(fifo_cnt_o), 64'd0);
    @(posedge clk); #1;
    sqrt_finish_valid_i = 0;
    #1;
    chk("t1.rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("t1.rsp_tag", 64'(rsp_tag_o), 64'd5);
    chk("t1.rsp_res", rsp_res_o, 64'h4000_0000_0000_0000);
    chk("t1.rsp_fflags", 64'(rsp_fflags_o), 64'h1);
    chk("t1.busy_rsp", 64'(busy_o), 64'd1);
    rsp_ready_i = 1;
    @(posedge clk); #1;
    rsp_ready_i = 0;
    #1;
    chk("t1.rsp_valid_clr", 64'(rsp_valid_o), 64'd0);
    chk("t1.busy_clr", 64'(busy_o), 64'd0);
  endtask

  task automatic run_rand(input int n, input int tbase, input int hold);
    req_t start_q[$];
    req_t rsp_q[$];
    req_t cur, e;
    bit have_cur, u_busy;
    logic [63:0] u_op;
    int u_wait, issued, rcvd, cyc;
    bit req_hs, start_hs, fin_hs, rsp_hs;
    have_cur = 0; u_busy = 0; u_op = '0; u_wait = 0;
    issued = 0; rcvd = 0; cyc = 0;
    while (rcvd < n && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      chk("rand.fifo_cnt", 64'(fifo_cnt_o), 64'(start_q.size()));
      if (!have_cur && issued < n) begin
        cur.op  = {$urandom, $urandom};
        cur.fmt = 2'($urandom_range(0, 3));
        cur.rm  = 3'($urandom_range(0, 7));
        cur.tag = 5'(tbase + issued);
        have_cur = 1;
      end
      req_valid_i = have_cur && ($urandom_range(0, 3) != 0);
      req_op_i = cur.op; req_fmt_i = cur.fmt;
      req_rm_i = cur.rm; req_tag_i = cur.tag;
      sqrt_start_ready_i = ($urandom_range(0, 2) != 0);
      rsp_ready_i = (cyc > hold) && ($urandom_range(0, 3) != 0);
      sqrt_finish_valid_i = u_busy && (u_wait == 0);
      sqrt_res_i = u_op ^ K;
      sqrt_fflags_i = u_op[4:0];
      #1;
      req_hs   = req_valid_i & req_ready_o;
      start_hs = sqrt_start_valid_o & sqrt_start_ready_i;
      fin_hs   = sqrt_finish_valid_i & sqrt_finish_ready_o;
      rsp_hs   = rsp_valid_o & rsp_ready_i;
      if (rsp_valid_o && !rsp_ready_i)
        chk("rand.fin_ready_held", 64'(sqrt_finish_ready_o), 64'd0);
      if (req_hs) begin
        start_q.push_back(cur);
        have_cur = 0;
        issued++;
      end
      if (start_hs) begin
        chk("rand.start_has_req", 64'(start_q.size() != 0), 64'd1);
        if (start_q.size() != 0) begin
          e = start_q.pop_front();
          chk("rand.sqrt_op", sqrt_op_o, e.op);
          chk("rand.sqrt_fmt", 64'(sqrt_fmt_o), 64'(e.fmt));
          chk("rand.sqrt_rm", 64'(sqrt_rm_o), 64'(e.rm));
          rsp_q.push_back(e);
        end
        u_busy = 1;
        u_op = sqrt_op_o;
        u_wait = $urandom_range(0, 3);
      end else if (fin_hs) begin
        u_busy = 0;
      end else if (u_busy && u_wait > 0) begin
        u_wait--;
      end
      if (rsp_hs) begin
        chk("rand.rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("rand.rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
          chk("rand.rsp_res", rsp_res_o, e.op ^ K);
          chk("rand.rsp_fflags", 64'(rsp_fflags_o), 64'(e.op[4:0]));
        end
        rcvd++;
      end
    end
    chk("rand.all_returned", 64'(rcvd), 64'(n));
    chk("rand.none_left", 64'(start_q.size() + rsp_q.size()), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    chk("rand.idle_after", 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    #12;
    chk("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst.fifo_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("rst.start_valid", 64'(sqrt_start_valid_o), 64'd0);
    chk("rst.fin_ready", 64'(sqrt_finish_ready_o), 64'd0);
    chk("rst.busy", 64'(busy_o), 64'd0);
    chk("rst.rsp_tag", 64'(rsp_tag_o), 64'd0);
    chk("rst.rsp_res", rsp_res_o, 64'd0);
    chk("rst.req_ready", 64'(req_ready_o), 64'd1);
    #10;
    rst_n = 1;
    single_op();
    run_table();
    run_rand(3, 1, 25);
    run_rand(10, 0, 0);
    run_rand(60, 7, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
